// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control unit: sequences IF/ID/EXE/MEM/WB for the MIPS-subset datapath.
// Latency: 2 (j/jr/jal/nop), 3 (branches), 4 (R/I-type ALU, sw), 5 (lw) cycles.
// Backpressure: none; advances one state per clock, HALT holds until Reset.
//
// Ports:
//   CLK, Reset          rising-edge clock, synchronous active-high reset
//   op, zero, sign      opcode from the IR; ALU zero flag and result bit 31
//   state               current FSM state (IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=111)
//   IRWre, PCWre        IR load, PC load
//   PCSrc               next-PC select (PC+4, branch target, rs, jump target)
//   ALUSrcA/B, ALUOp    ALU operand selects and operation code
//   ExtSel              immediate extension (1 sign, 0 zero)
//   RegDst, RegWre      write-register select and register-file write enable
//   WrRegDSrc           register write data (0 PC+4, 1 data bus)
//   DBDataSrc           data bus source (0 ALU result, 1 memory)
//   mRD, mWR            data memory read/write
//   retired             completed-instruction count
module multi_cycle_control_unit (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [5:0]  op,
   input  logic        zero,
   input  logic        sign,
   output logic [2:0]  state,
   output logic        IRWre,
   output logic        PCWre,
   output logic [1:0]  PCSrc,
   output logic        ALUSrcA,
   output logic        ALUSrcB,
   output logic [2:0]  ALUOp,
   output logic        ExtSel,
   output logic [1:0]  RegDst,
   output logic        RegWre,
   output logic        WrRegDSrc,
   output logic        DBDataSrc,
   output logic        mRD,
   output logic        mWR,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      sIF   = 3'b000,
      sID   = 3'b001,
      sEXE  = 3'b010,
      sMEM  = 3'b011,
      sWB   = 3'b100,
      sHALT = 3'b111
   } stateT;

   localparam logic [5:0] opAdd   = 6'b000000;
   localparam logic [5:0] opSub   = 6'b000001;
   localparam logic [5:0] opAddiu = 6'b000010;
   localparam logic [5:0] opAnd   = 6'b010000;
   localparam logic [5:0] opAndi  = 6'b010001;
   localparam logic [5:0] opOri   = 6'b010010;
   localparam logic [5:0] opXori  = 6'b010011;
   localparam logic [5:0] opSll   = 6'b011000;
   localparam logic [5:0] opSlti  = 6'b100110;
   localparam logic [5:0] opSlt   = 6'b100111;
   localparam logic [5:0] opSw    = 6'b110000;
   localparam logic [5:0] opLw    = 6'b110001;
   localparam logic [5:0] opBeq   = 6'b110100;
   localparam logic [5:0] opBne   = 6'b110101;
   localparam logic [5:0] opBltz  = 6'b110110;
   localparam logic [5:0] opJ     = 6'b111000;
   localparam logic [5:0] opJr    = 6'b111001;
   localparam logic [5:0] opJal   = 6'b111010;
   localparam logic [5:0] opHalt  = 6'b111111;

   stateT curState;
   stateT nextState;

   logic isAdd, isSub, isAddiu, isAnd, isAndi, isOri, isXori, isSll;
   logic isSlti, isSlt, isSw, isLw, isBeq, isBne, isBltz;
   logic isJ, isJr, isJal, isHalt;
   logic isRType, isIType, isBranch, isNop;

   assign isAdd   = (op == opAdd);
   assign isSub   = (op == opSub);
   assign isAddiu = (op == opAddiu);
   assign isAnd   = (op == opAnd);
   assign isAndi  = (op == opAndi);
   assign isOri   = (op == opOri);
   assign isXori  = (op == opXori);
   assign isSll   = (op == opSll);
   assign isSlti  = (op == opSlti);
   assign isSlt   = (op == opSlt);
   assign isSw    = (op == opSw);
   assign isLw    = (op == opLw);
   assign isBeq   = (op == opBeq);
   assign isBne   = (op == opBne);
   assign isBltz  = (op == opBltz);
   assign isJ     = (op == opJ);
   assign isJr    = (op == opJr);
   assign isJal   = (op == opJal);
   assign isHalt  = (op == opHalt);

   assign isRType  = isAdd | isSub | isAnd | isSlt | isSll;
   assign isIType  = isAddiu | isAndi | isOri | isXori | isSlti | isLw;
   assign isBranch = isBeq | isBne | isBltz;
   // Anything outside the supported set retires as a two-cycle nop.
   assign isNop    = ~(isRType | isIType | isBranch | isSw | isJ | isJr | isJal | isHalt);

   assign state = curState;

   // State register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         curState <= sIF;
      end else begin
         curState <= nextState;
      end
   end

   // Next state and sequencing enables.
   always_comb begin
      nextState = sIF;
      IRWre     = 1'b0;
      PCWre     = 1'b0;
      RegWre    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;

      case (curState)
         sIF: begin
            nextState = sID;
         end
         sID: begin
            if (isJ | isJr | isJal | isNop) begin
               nextState = sIF;
            end else if (isHalt) begin
               nextState = sHALT;
            end else begin
               nextState = sEXE;
            end
         end
         sEXE: begin
            if (isBranch) begin
               nextState = sIF;
            end else if (isSw | isLw) begin
               nextState = sMEM;
            end else begin
               nextState = sWB;
            end
         end
         sMEM: begin
            nextState = isSw ? sIF : sWB;
         end
         sWB: begin
            nextState = sIF;
         end
         sHALT: begin
            nextState = sHALT;
         end
         default: begin
            nextState = sIF;
         end
      endcase

      IRWre = (curState == sIF);
      mRD   = (curState == sMEM) & isLw;

      // Reset overrides the decode so no architectural state is touched in
      // the cycle that aborts an instruction.
      PCWre  = ~Reset & (nextState == sIF);
      RegWre = ~Reset & ((curState == sWB) | ((curState == sID) & isJal));
      mWR    = ~Reset & (curState == sMEM) & isSw;
   end

   // Datapath selects: pure opcode decode, stable for the whole instruction.
   always_comb begin
      ALUSrcA   = isSll;
      ALUSrcB   = isAddiu | isAndi | isOri | isXori | isSlti | isSw | isLw;
      ExtSel    = ~(isAndi | isOri | isXori);
      WrRegDSrc = ~isJal;
      DBDataSrc = isLw;

      ALUOp = 3'b000;
      if (isSub | isBranch) begin
         ALUOp = 3'b001;
      end else if (isSll) begin
         ALUOp = 3'b010;
      end else if (isOri) begin
         ALUOp = 3'b011;
      end else if (isAnd | isAndi) begin
         ALUOp = 3'b100;
      end else if (isSlt | isSlti) begin
         ALUOp = 3'b110;
      end else if (isXori) begin
         ALUOp = 3'b111;
      end

      // jal writes $31, which is the 00 default.
      RegDst = 2'b00;
      if (isRType) begin
         RegDst = 2'b10;
      end else if (isIType) begin
         RegDst = 2'b01;
      end

      PCSrc = 2'b00;
      if (isJ | isJal) begin
         PCSrc = 2'b11;
      end else if (isJr) begin
         PCSrc = 2'b10;
      end else if ((isBeq & zero) | (isBne & ~zero) | (isBltz & sign)) begin
         PCSrc = 2'b01;
      end
   end

   // Every PC load completes an instruction.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         retired <= 32'd0;
      end else if (PCWre) begin
         retired <= retired + 32'd1;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

   logic        CLK;
   logic        Reset;
   logic [5:0]  op;
   logic        zero;
   logic        sign;
   logic [2:0]  state;
   logic        IRWre;
   logic        PCWre;
   logic [1:0]  PCSrc;
   logic        ALUSrcA;
   logic        ALUSrcB;
   logic [2:0]  ALUOp;
   logic        ExtSel;
   logic [1:0]  RegDst;
   logic        RegWre;
   logic        WrRegDSrc;
   logic        DBDataSrc;
   logic        mRD;
   logic        mWR;
   logic [31:0] retired;

   multi_cycle_control_unit dut (
      .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
      .state(state), .IRWre(IRWre), .PCWre(PCWre), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
      .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
      .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .retired(retired)
   );

   localparam logic [5:0] ADD  = 6'b000000;
   localparam logic [5:0] LW   = 6'b110001;
   localparam logic [5:0] SW   = 6'b110000;
   localparam logic [5:0] ORI  = 6'b010010;
   localparam logic [5:0] SLL  = 6'b011000;
   localparam logic [5:0] BEQ  = 6'b110100;
   localparam logic [5:0] BNE  = 6'b110101;
   localparam logic [5:0] BLTZ = 6'b110110;
   localparam logic [5:0] J    = 6'b111000;
   localparam logic [5:0] JR   = 6'b111001;
   localparam logic [5:0] JAL  = 6'b111010;
   localparam logic [5:0] HALT = 6'b111111;
   localparam logic [5:0] NOP  = 6'b000011;

   // Expected response for one cycle.
   // core = {state, IRWre, PCWre, RegWre, mRD, mWR, retired}
   // aux  = {PCSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst, WrRegDSrc, DBDataSrc}
   typedef struct {
      string       nm;
      logic [39:0] ce;
      logic [39:0] cm;
      logic [11:0] ae;
      logic [11:0] am;
   } expT;

   expT sb[$];
   int  checks = 0;
   int  errors = 0;
   int  r = 0;

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   function automatic logic [11:0] aux(logic [1:0] pcs, logic a, logic b, logic [2:0] alu,
                                       logic ext, logic [1:0] rd, logic wr, logic db);
      return {pcs, a, b, alu, ext, rd, wr, db};
   endfunction

   // Monitor: one expectation per cycle, compared away from the active edge.
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         expT e;
         logic [39:0] ac;
         logic [11:0] aa;
         e  = sb.pop_front();
         ac = {state, IRWre, PCWre, RegWre, mRD, mWR, retired};
         aa = {PCSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst, WrRegDSrc, DBDataSrc};
         if (e.cm != 40'd0) begin
            checks++;
            if ((ac & e.cm) !== (e.ce & e.cm)) begin
               errors++;
               $display("FAIL %s core: got %h required %h (mask %h)", e.nm, ac & e.cm, e.ce & e.cm, e.cm);
            end
         end
         if (e.am != 12'd0) begin
            checks++;
            if ((aa & e.am) !== (e.ae & e.am)) begin
               errors++;
               $display("FAIL %s aux: got %h required %h (mask %h)", e.nm, aa & e.am, e.ae & e.am, e.am);
            end
         end
      end
   end

   // Drive one cycle and queue its expectation; -1 means don't care.
   task automatic cyc(input string nm, input logic [5:0] o, input logic z, input logic s,
                      input logic rst, input int st, input int irw, input int pcw, input int rgw,
                      input int mrd, input int mwr, input int ret,
                      input logic [11:0] ae, input logic [11:0] am);
      expT e;
      op = o; zero = z; sign = s; Reset = rst;
      e.nm = nm;
      e.ce = {st[2:0], irw[0], pcw[0], rgw[0], mrd[0], mwr[0], ret[31:0]};
      e.cm = {{3{st != -1}}, irw != -1, pcw != -1, rgw != -1, mrd != -1, mwr != -1, {32{ret != -1}}};
      e.ae = ae;
      e.am = am;
      sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   // Cycle that does not complete the instruction.
   task automatic idle(input string nm, input logic [5:0] o, input logic z, input logic s,
                       input int st, input logic [11:0] ae = 12'd0, input logic [11:0] am = 12'd0);
      cyc(nm, o, z, s, 1'b0, st, (st == 0) ? 1 : 0, 0, 0, 0, 0, r, ae, am);
   endtask

   // Cycle that completes the instruction (PCWre=1).
   task automatic done(input string nm, input logic [5:0] o, input logic z, input logic s,
                       input int st, input int rgw, input int mrd, input int mwr,
                       input logic [11:0] ae = 12'd0, input logic [11:0] am = 12'd0);
      cyc(nm, o, z, s, 1'b0, st, 0, 1, rgw, mrd, mwr, r, ae, am);
      r++;
   endtask

   initial begin
      logic [11:0] aAdd, aLw, aOri, aSll, aSw;
      aAdd = aux(2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10, 1'b1, 1'b0);
      aLw  = aux(2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01, 1'b1, 1'b1);
      aOri = aux(2'b00, 1'b0, 1'b1, 3'b011, 1'b0, 2'b01, 1'b1, 1'b0);
      aSll = aux(2'b00, 1'b1, 1'b0, 3'b010, 1'b1, 2'b10, 1'b1, 1'b0);
      aSw  = aux(2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0);

      // Reset
      cyc("rst0", ADD, 0, 0, 1'b1, -1, -1, -1, -1, -1, -1, -1, 12'd0, 12'd0);
      cyc("rst1", ADD, 0, 0, 1'b1, 0, 1, 0, 0, 0, 0, 0, 12'd0, 12'd0);

      // add: IF ID EXE WB
      idle("add.if",  ADD, 0, 0, 0);
      idle("add.id",  ADD, 0, 0, 1, aAdd, 12'hFFF);
      idle("add.exe", ADD, 0, 0, 2, aAdd, 12'hFFF);
      done("add.wb",  ADD, 0, 0, 4, 1, 0, 0, aAdd, 12'hFFF);

      // lw: IF ID EXE MEM WB
      idle("lw.if",  LW, 0, 0, 0);
      idle("lw.id",  LW, 0, 0, 1, aLw, 12'hFFF);
      idle("lw.exe", LW, 0, 0, 2, aLw, 12'hFFF);
      cyc("lw.mem",  LW, 0, 0, 1'b0, 3, 0, 0, 0, 1, 0, r, aLw, 12'hFFF);
      done("lw.wb",  LW, 0, 0, 4, 1, 0, 0, aLw, 12'hFFF);

      // Branches resolve in EXE; only PCSrc and ALUOp checked there.
      idle("beqT.if", BEQ, 1, 0, 0);
      idle("beqT.id", BEQ, 1, 0, 1);
      done("beqT.exe", BEQ, 1, 0, 2, 0, 0, 0, aux(2'b01, 0, 0, 3'b001, 1, 2'b00, 1, 0), 12'hCE0);
      idle("beqN.if", BEQ, 0, 0, 0);
      idle("beqN.id", BEQ, 0, 0, 1);
      done("beqN.exe", BEQ, 0, 0, 2, 0, 0, 0, aux(2'b00, 0, 0, 3'b001, 1, 2'b00, 1, 0), 12'hCE0);
      idle("bneT.if", BNE, 0, 0, 0);
      idle("bneT.id", BNE, 0, 0, 1);
      done("bneT.exe", BNE, 0, 0, 2, 0, 0, 0, aux(2'b01, 0, 0, 3'b001, 1, 2'b00, 1, 0), 12'hCE0);
      idle("bltzT.if", BLTZ, 0, 1, 0);
      idle("bltzT.id", BLTZ, 0, 1, 1);
      done("bltzT.exe", BLTZ, 0, 1, 2, 0, 0, 0, aux(2'b01, 0, 0, 3'b001, 1, 2'b00, 1, 0), 12'hCE0);
      idle("bltzN.if", BLTZ, 1, 0, 0);
      idle("bltzN.id", BLTZ, 1, 0, 1);
      done("bltzN.exe", BLTZ, 1, 0, 2, 0, 0, 0, aux(2'b00, 0, 0, 3'b001, 1, 2'b00, 1, 0), 12'hCE0);

      // Jumps and nop: IF ID
      idle("jal.if", JAL, 0, 0, 0);
      done("jal.id", JAL, 0, 0, 1, 1, 0, 0, aux(2'b11, 0, 0, 3'b000, 1, 2'b00, 1'b0, 0), 12'hC0E);
      idle("jr.if", JR, 0, 0, 0);
      done("jr.id", JR, 0, 0, 1, 0, 0, 0, aux(2'b10, 0, 0, 3'b000, 1, 2'b00, 1, 0), 12'hC00);
      idle("j.if", J, 0, 0, 0);
      done("j.id", J, 0, 0, 1, 0, 0, 0, aux(2'b11, 0, 0, 3'b000, 1, 2'b00, 1, 0), 12'hC00);
      idle("nop.if", NOP, 0, 0, 0);
      done("nop.id", NOP, 0, 0, 1, 0, 0, 0, aux(2'b00, 0, 0, 3'b000, 1, 2'b00, 1, 0), 12'hCE0);

      // I-type with zero extension, and a shift
      idle("ori.if",  ORI, 0, 0, 0);
      idle("ori.id",  ORI, 0, 0, 1, aOri, 12'hFFF);
      idle("ori.exe", ORI, 0, 0, 2, aOri, 12'hFFF);
      done("ori.wb",  ORI, 0, 0, 4, 1, 0, 0);
      idle("sll.if",  SLL, 0, 0, 0);
      idle("sll.id",  SLL, 0, 0, 1);
      idle("sll.exe", SLL, 0, 0, 2, aSll, 12'hFFF);
      done("sll.wb",  SLL, 0, 0, 4, 1, 0, 0);

      // sw: IF ID EXE MEM
      idle("sw.if",  SW, 0, 0, 0);
      idle("sw.id",  SW, 0, 0, 1);
      idle("sw.exe", SW, 0, 0, 2, aSw, 12'hFF3);
      done("sw.mem", SW, 0, 0, 3, 0, 0, 1, aSw, 12'hFF3);

      // halt holds for 10 cycles, then reset returns to IF with retired cleared
      idle("halt.if", HALT, 0, 0, 0);
      idle("halt.id", HALT, 0, 0, 1);
      for (int i = 0; i < 10; i++) idle("halt.hold", HALT, 0, 0, 7);
      cyc("halt.rst", HALT, 0, 0, 1'b1, 7, 0, -1, 0, 0, 0, r, 12'd0, 12'd0);
      r = 0;
      idle("postHalt.if", NOP, 0, 0, 0);
      done("postHalt.id", NOP, 0, 0, 1, 0, 0, 0);

      // Reset in MEM of sw suppresses the write and returns to IF
      idle("swRst.if",  SW, 0, 0, 0);
      idle("swRst.id",  SW, 0, 0, 1);
      idle("swRst.exe", SW, 0, 0, 2);
      cyc("swRst.mem",  SW, 0, 0, 1'b1, 3, 0, -1, 0, -1, 0, r, 12'd0, 12'd0);
      r = 0;
      idle("postSwRst.if", ADD, 0, 0, 0);
      idle("postSwRst.id", ADD, 0, 0, 1);

      @(negedge CLK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Multi-cycle control unit for the team's MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It generates the ALU operand selects and ALU operation code that the datapath ALU consumes, plus all register-file, memory and PC controls. It sits between the instruction register (opcode in) and the datapath (control out), and takes the ALU `zero` flag and the sign bit back for branch resolution.

## Interface
No parameters.
- `CLK` in 1: rising-edge clock
- `Reset` in 1: synchronous, active-high
- `op` in 6: opcode field of the instruction register
- `zero` in 1: ALU zero flag
- `sign` in 1: ALU result bit 31
- `state` out 3: current state (IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111)
- `IRWre` out 1: instruction register load
- `PCWre` out 1: PC load
- `PCSrc` out 2: 00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target
- `ALUSrcA` out 1: 1 selects shamt
- `ALUSrcB` out 1: 1 selects extended immediate
- `ALUOp` out 3: 000 add, 001 sub, 010 shl, 011 or, 100 and, 101 sltu, 110 slt, 111 xor
- `ExtSel` out 1: 1 sign-extend, 0 zero-extend
- `RegDst` out 2: 00 $31, 01 rt, 10 rd
- `RegWre` out 1: register-file write
- `WrRegDSrc` out 1: 0 PC+4, 1 data bus
- `DBDataSrc` out 1: 0 ALU result, 1 memory data
- `mRD` out 1: data memory read
- `mWR` out 1: data memory write
- `retired` out 32: completed-instruction count

## Operation
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is a nop.
- The state register is the only FSM storage. All control outputs are combinational from `state`, `op`, `zero` and `sign`.
- Transitions:
  - IF→ID always.
  - ID→IF for j, jr, jal and nop. ID→HALT for halt. ID→EXE otherwise.
  - EXE→IF for beq, bne and bltz. EXE→MEM for sw and lw. EXE→WB otherwise.
  - MEM→IF for sw. MEM→WB for lw.
  - WB→IF.
  - HALT→HALT until `Reset`.
- IRWre is 1 only in IF.
- PCWre is 1 exactly in the cycle whose next state is IF. It is never 1 in HALT.
- ALU controls are held valid in ID, EXE, MEM and WB:
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addiu, andi, ori, xori, slti, sw and lw.
  - ALUOp=000 for add, addiu, sw and lw.
  - ALUOp=001 for sub, beq, bne and bltz.
  - ALUOp=010 for sll; 011 for ori; 100 for and and andi; 110 for slt and slti; 111 for xori.
  - ALUOp=000 for all other opcodes.
- ExtSel=0 for andi, ori and xori. ExtSel=1 otherwise.
- PCSrc:
  - 11 for j and jal; 10 for jr.
  - 01 for beq&zero, bne&!zero and bltz&sign.
  - 00 otherwise, including untaken branches.
- RegWre:
  - 1 in WB for every instruction that reaches WB.
  - 1 in ID for jal, with RegDst=00 and WrRegDSrc=0.
  - 0 in all other cycles.
- RegDst: 10 for R-type (add, sub, and, slt, sll); 01 for I-type and lw.
- WrRegDSrc=1 except for jal.
- DBDataSrc=1 only for lw.
- mRD=1 only in MEM for lw. mWR=1 only in MEM for sw.
- `retired` increments by 1 (mod 2^32, wrapping) in every cycle where PCWre=1.

## Timing
- Latency in cycles:
  - j, jr, jal, nop: 2
  - beq, bne, bltz: 3
  - sw: 4
  - R-type and arithmetic/logic I-type: 4
  - lw: 5
- `zero` and `sign` are sampled combinationally in EXE. The PC update takes effect at the EXE→IF edge.
- Reset values: `state`=IF and `retired`=0. Outputs follow from IF: IRWre=1 and all other enables 0.
- Reset asserted in any state, including HALT or mid-instruction, forces IF on the next edge. No mWR or RegWre is issued in that cycle (reset overrides the decode).

## Test plan
- Reset, then op=000000 held: states IF,ID,EXE,WB,IF. RegWre=1 only in WB, PCWre=1 only in WB, `retired`=1.
- op=110001 (lw): states IF,ID,EXE,MEM,WB,IF. mRD=1 in MEM, DBDataSrc=1, RegDst=01, ALUSrcB=1, ALUOp=000.
- op=110100 with zero=1 then zero=0: PCSrc=01 then 00 in EXE. 3-cycle latency each; RegWre never asserted.
- op=111010 (jal): IF,ID,IF. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- op=111111: enters HALT (`state`=111), PCWre stays 0 for 10 cycles. Reset returns to IF with `retired`=0.
- Reset asserted in MEM of sw: mWR=0 in that cycle, next state IF.
